ads1672_sample_fifo: RTL and testbench

ADS1672_SAMPLE_FIFO -- requirements
Module: ads1672_sample_fifo

---
 rtl/ads1672_pkg.sv | 28 ++
 rtl/ads1672_sync_fifo.sv | 59 +++++
 rtl/ads1672_sample_fifo.sv | 160 ++++++++++++++++
 tb/tb_ads1672_sample_fifo.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ads1672_pkg.sv
// Shared constants for the ADS1672 sample FIFO: register addresses,
// STATUS/CONTROL bit positions and field widths.
package ads1672_pkg;

  // Avalon-MM word addresses
  typedef enum logic [1:0] {
    AddrData    = 2'd0,
    AddrStatus  = 2'd1,
    AddrControl = 2'd2,
    AddrTstamp  = 2'd3
  } reg_addr_e;

  // STATUS layout
  localparam int unsigned StatusCountWidth  = 11;
  localparam int unsigned StatusOverflowBit = 16;
  localparam int unsigned StatusEmptyBit    = 17;
  localparam int unsigned StatusFullBit     = 18;

  // CONTROL layout
  localparam int unsigned CtrlEnableBit = 0;
  localparam int unsigned CtrlClearBit  = 1;
  localparam int unsigned CtrlThreshLsb = 16;
  localparam int unsigned ThreshWidth   = 10;

  // Timestamp width (used only when timestamps are built in)
  localparam int unsigned TstampWidth = 32;

endpackage

// File: rtl/ads1672_sync_fifo.sv
// Single-clock FIFO with push/pop/clear and full/empty/count flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module ads1672_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PtrWidth   = $clog2(DEPTH);
  localparam int unsigned CountWidth = PtrWidth + 1;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [PtrWidth-1:0]   wptr_q;
  logic [PtrWidth-1:0]   rptr_q;
  logic [CountWidth-1:0] count_q;
  logic                  push_ok;
  logic                  pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CountWidth'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A push into a full FIFO is accepted only when a pop frees the head slot
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem_q[rptr_q];
  assign count   = count_q;

  // Pointer and occupancy tracking; clear overrides any concurrent push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clear) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PtrWidth'(1);
      if (pop_ok)  rptr_q <= rptr_q + PtrWidth'(1);
      count_q <= count_q + CountWidth'(push_ok) - CountWidth'(pop_ok);
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/ads1672_sample_fifo.sv
// ADS1672 sample FIFO with an Avalon-MM register interface and a
// threshold interrupt. Define ADS1672_TSTAMP_EN to capture a free-running
// cycle count alongside each accepted sample (readable via TSTAMP).
module ads1672_sample_fifo
  import ads1672_pkg::*;
#(
  parameter int unsigned ADC_DATA_WIDTH = 24,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DEPTH          = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADC_DATA_WIDTH-1:0] sample_data,
  input  logic                      sample_valid,
  input  logic [1:0]                address,
  input  logic                      read,
  input  logic                      write,
  input  logic [DATA_WIDTH-1:0]     writedata,
  output logic [DATA_WIDTH-1:0]     readdata,
  output logic                      irq
);

`ifdef ADS1672_TSTAMP_EN
  localparam int unsigned FifoWidth = DATA_WIDTH + TstampWidth;
`else
  localparam int unsigned FifoWidth = DATA_WIDTH;
`endif

  reg_addr_e                   addr;
  logic                        ctrl_wr;
  logic                        clear_pulse;
  logic                        data_rd;
  logic                        push;
  logic                        pop;
  logic [DATA_WIDTH-1:0]       sample_ext;
  logic [FifoWidth-1:0]        fifo_wdata;
  logic [FifoWidth-1:0]        fifo_rdata;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(DEPTH):0]      fifo_count;
  logic [StatusCountWidth-1:0] count_ext;
  logic [DATA_WIDTH-1:0]       status_word;
  logic [DATA_WIDTH-1:0]       control_word;
  logic [DATA_WIDTH-1:0]       rd_mux;
  logic                        enable_q;
  logic [ThreshWidth-1:0]      thresh_q;
  logic                        overflow_q;
  logic [DATA_WIDTH-1:0]       readdata_q;
  logic                        irq_q;
  logic                        unused_writedata;

  assign addr        = reg_addr_e'(address);
  assign ctrl_wr     = write && (addr == AddrControl);
  assign clear_pulse = ctrl_wr && writedata[CtrlClearBit];
  assign data_rd     = read && (addr == AddrData);
  assign pop         = data_rd && !fifo_empty;
  assign push        = sample_valid && enable_q && !clear_pulse;
  assign sample_ext  = {{(DATA_WIDTH - ADC_DATA_WIDTH){sample_data[ADC_DATA_WIDTH-1]}}, sample_data};
  assign count_ext   = StatusCountWidth'(fifo_count);

  // Only the enable, clear and threshold fields of writedata are meaningful
  assign unused_writedata = ^{writedata[DATA_WIDTH-1:CtrlThreshLsb+ThreshWidth],
                              writedata[CtrlThreshLsb-1:CtrlClearBit+1]};

`ifdef ADS1672_TSTAMP_EN
  logic [TstampWidth-1:0] tstamp_q;

  // Free-running cycle counter stamped onto each accepted sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tstamp_q <= '0;
    else     tstamp_q <= tstamp_q + TstampWidth'(1);
  end

  assign fifo_wdata = {tstamp_q, sample_ext};
`else
  assign fifo_wdata = sample_ext;
`endif

  ads1672_sync_fifo #(
    .WIDTH (FifoWidth),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (clear_pulse),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Control register; a write carrying the clear bit leaves enable/threshold alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_q <= 1'b0;
      thresh_q <= '0;
    end else if (ctrl_wr && !writedata[CtrlClearBit]) begin
      enable_q <= writedata[CtrlEnableBit];
      thresh_q <= writedata[CtrlThreshLsb +: ThreshWidth];
    end
  end

  // Sticky overflow: set when a sample is dropped, cleared only by clear pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (clear_pulse) begin
      overflow_q <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow_q <= 1'b1;
    end
  end

  // Assemble STATUS and CONTROL read views
  always_comb begin
    status_word                            = '0;
    status_word[StatusCountWidth-1:0]      = count_ext;
    status_word[StatusOverflowBit]         = overflow_q;
    status_word[StatusEmptyBit]            = fifo_empty;
    status_word[StatusFullBit]             = fifo_full;
    control_word                           = '0;
    control_word[CtrlEnableBit]            = enable_q;
    control_word[CtrlThreshLsb +: ThreshWidth] = thresh_q;
  end

  // Read-data select for the addressed register
  always_comb begin
    rd_mux = '0;
    unique case (addr)
      AddrData:    rd_mux = fifo_empty ? '0 : fifo_rdata[DATA_WIDTH-1:0];
      AddrStatus:  rd_mux = status_word;
      AddrControl: rd_mux = control_word;
`ifdef ADS1672_TSTAMP_EN
      AddrTstamp:  rd_mux = fifo_empty ? '0 :
                            DATA_WIDTH'(fifo_rdata[FifoWidth-1 -: TstampWidth]);
`else
      AddrTstamp:  rd_mux = '0;
`endif
      default:     rd_mux = '0;
    endcase
  end

  // Registered read data (latency 1, held between reads) and threshold irq
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (read) readdata_q <= rd_mux;
      irq_q <= enable_q && (thresh_q != '0) && (count_ext >= {1'b0, thresh_q});
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_ads1672_sample_fifo.sv
// Directed bench for ads1672_sample_fifo. Covers the TSTAMP path when
// ADS1672_TSTAMP_EN is defined, otherwise checks TSTAMP reads 0.
module tb_ads1672_sample_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] sample_data = '0;
  logic        sample_valid = 1'b0;
  logic [1:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;

  int tests = 0;
  int fails = 0;
  logic [31:0] d;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_STAT = 2'd1;
  localparam logic [1:0] A_CTRL = 2'd2;
  localparam logic [1:0] A_TS   = 2'd3;

  ads1672_sample_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .readdata     (readdata),
    .irq          (irq)
  );

  always #5 clk = ~clk;

`ifdef ADS1672_TSTAMP_EN
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [23:0] v);
    sample_data  = v;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] q);
    address = a;
    read    = 1'b1;
    tick();
    read = 1'b0;
    q    = readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    address   = a;
    writedata = v;
    write     = 1'b1;
    tick();
    write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;
    rd(A_STAT, d); check("rst_status", d, 32'h0002_0000);
    rd(A_CTRL, d); check("rst_control", d, 32'h0);
    rd(A_DATA, d); check("empty_data_read", d, 32'h0);
    rd(A_STAT, d); check("empty_read_no_change", d, 32'h0002_0000);

    // Enable, ignored writes to RO addresses
    wr(A_CTRL, 32'h0000_0001);
    rd(A_CTRL, d); check("ctrl_enable", d, 32'h0000_0001);
    wr(A_STAT, 32'hFFFF_FFFF);
    wr(A_DATA, 32'h1234_5678);
    rd(A_STAT, d); check("ro_write_ignored", d, 32'h0002_0000);

    // Sign extension
    push(24'h7FFFFF); push(24'h800000); push(24'h000001);
    rd(A_DATA, d); check("sext_pos_max", d, 32'h007F_FFFF);
    rd(A_DATA, d); check("sext_neg_min", d, 32'hFF80_0000);
    rd(A_DATA, d); check("sext_one", d, 32'h0000_0001);
    rd(A_STAT, d); check("sext_status_empty", d, 32'h0002_0000);

    // Push and read together while empty
    sample_data = 24'h123456; sample_valid = 1'b1; address = A_DATA; read = 1'b1;
    tick();
    sample_valid = 1'b0; read = 1'b0;
    check("empty_push_read_data", readdata, 32'h0);
    rd(A_STAT, d); check("empty_push_read_count", d, 32'h0000_0001);
    rd(A_DATA, d); check("empty_push_read_stored", d, 32'h0012_3456);

    // Overflow: 65 pushes into 64 entries
    for (int i = 0; i < 65; i++) push(24'h000100 + 24'(i));
    rd(A_STAT, d); check("ovf_status", d, 32'h0005_0040);
    for (int i = 0; i < 64; i++) begin
      rd(A_DATA, d); check($sformatf("ovf_order_%0d", i), d, 32'h0000_0100 + 32'(i));
    end
    rd(A_STAT, d); check("ovf_sticky_empty", d, 32'h0003_0000);
    wr(A_CTRL, 32'h0000_0002);
    rd(A_STAT, d); check("clear_after_ovf", d, 32'h0002_0000);

    // Full FIFO, simultaneous push and pop
    for (int i = 0; i < 64; i++) push(24'h000200 + 24'(i));
    rd(A_STAT, d); check("full_status", d, 32'h0004_0040);
    sample_data = 24'hABCDEF; sample_valid = 1'b1; address = A_DATA; read = 1'b1;
    tick();
    sample_valid = 1'b0; read = 1'b0;
    check("full_pushpop_head", readdata, 32'h0000_0200);
    rd(A_STAT, d); check("full_pushpop_status", d, 32'h0004_0040);
    for (int i = 1; i < 64; i++) begin
      rd(A_DATA, d); check($sformatf("full_drain_%0d", i), d, 32'h0000_0200 + 32'(i));
    end
    rd(A_DATA, d); check("full_newest_last", d, 32'hFFAB_CDEF);
    rd(A_STAT, d); check("full_drained", d, 32'h0002_0000);

    // Threshold interrupt
    wr(A_CTRL, 32'h0004_0001);
    push(24'h10); push(24'h11); push(24'h12);
    tick();
    check("irq_below_thr", {31'b0, irq}, 32'h0);
    push(24'h13);
    check("irq_registered_lag", {31'b0, irq}, 32'h0);
    tick();
    check("irq_at_thr", {31'b0, irq}, 32'h1);
    rd(A_DATA, d); check("irq_pop_data", d, 32'h0000_0010);
    check("irq_held_one_cycle", {31'b0, irq}, 32'h1);
    tick();
    check("irq_after_pop", {31'b0, irq}, 32'h0);

    // Clear with 8 entries and overflow set, concurrent push dropped
    for (int i = 0; i < 62; i++) push(24'h000300 + 24'(i));
    for (int i = 0; i < 56; i++) rd(A_DATA, d);
    rd(A_STAT, d); check("pre_clear_status", d, 32'h0001_0008);
    sample_data = 24'h555555; sample_valid = 1'b1;
    wr(A_CTRL, 32'h0000_0002);
    sample_valid = 1'b0;
    rd(A_STAT, d); check("clear_status", d, 32'h0002_0000);
    check("clear_irq", {31'b0, irq}, 32'h0);
    rd(A_CTRL, d); check("clear_keeps_ctrl", d, 32'h0004_0001);
    rd(A_DATA, d); check("clear_push_dropped", d, 32'h0);

    // Disable: samples ignored, contents kept, reads drain
    push(24'hAAA); push(24'hBBB);
    wr(A_CTRL, 32'h0000_0000);
    push(24'hCCC);
    rd(A_STAT, d); check("disable_count", d, 32'h0000_0002);
    rd(A_DATA, d); check("disable_drain0", d, 32'h0000_0AAA);
    rd(A_DATA, d); check("disable_drain1", d, 32'h0000_0BBB);
    rd(A_STAT, d); check("disable_empty", d, 32'h0002_0000);

    // Timestamp register in the default build
    wr(A_CTRL, 32'h0004_0001);
    push(24'h1); push(24'h2); push(24'h3); push(24'h4);
`ifndef ADS1672_TSTAMP_EN
    rd(A_TS, d); check("tstamp_absent", d, 32'h0);
`endif

    // Reset mid-transfer with irq asserted
    tick();
    check("pre_reset_irq", {31'b0, irq}, 32'h1);
    rst = 1'b1;
    #2;
    check("async_rst_readdata", readdata, 32'h0);
    check("async_rst_irq", {31'b0, irq}, 32'h0);
    tick(); tick();
    rst = 1'b0;
    rd(A_STAT, d); check("post_rst_status", d, 32'h0002_0000);
    rd(A_CTRL, d); check("post_rst_control", d, 32'h0);
    rd(A_DATA, d); check("post_rst_data", d, 32'h0);

`ifdef ADS1672_TSTAMP_EN
    wr(A_CTRL, 32'h0000_0001);
    for (int k = 0; k < 100 && cyc != 10; k++) tick();
    check("ts_align10", cyc, 32'd10);
    push(24'h21);
    for (int k = 0; k < 100 && cyc != 25; k++) tick();
    check("ts_align25", cyc, 32'd25);
    push(24'h22);
    rd(A_TS, d); check("ts_first", d, 32'd10);
    rd(A_DATA, d); check("ts_first_data", d, 32'h0000_0021);
    rd(A_TS, d); check("ts_second", d, 32'd25);
    rd(A_DATA, d); check("ts_second_data", d, 32'h0000_0022);
    rd(A_TS, d); check("ts_empty", d, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
